// File: rtl/wordle_pkg.sv
// Shared types and constants for the guess-entry block.
// Letter, result and one-hot state codes used by top and scorer.
package wordle_pkg;

   localparam int WORD_LEN = 5;

   typedef logic [4:0] letter_t;
   typedef letter_t [WORD_LEN-1:0] word_t;
   typedef logic [1:0] res_t;
   typedef res_t [WORD_LEN-1:0] res_word_t;

   localparam letter_t LETTER_DEL   = 5'd26;
   localparam letter_t LETTER_ENTER = 5'd27;

   localparam res_t RES_GRAY   = 2'b00;
   localparam res_t RES_YELLOW = 2'b01;
   localparam res_t RES_GREEN  = 2'b10;

   localparam logic [2:0] LEN_FULL = 3'd5;
   localparam logic [2:0] LAST_IDX = 3'd4;

   localparam logic [4:0] ST_I      = 5'b00001;
   localparam logic [4:0] ST_ENTRY  = 5'b00010;
   localparam logic [4:0] ST_CHECK  = 5'b00100;
   localparam logic [4:0] ST_RESULT = 5'b01000;
   localparam logic [4:0] ST_DONE   = 5'b10000;

endpackage

// File: rtl/wordle_guess_scorer.sv
// Scores one guess against the target, one position per cycle.
// start kicks off a 5-cycle pass; done marks the last position.
module wordle_guess_scorer
   import wordle_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      clr,
   input  logic      start,
   input  word_t     guess,
   input  word_t     target,
   output logic      done,
   output logic      all_green,
   output res_word_t result
);

   logic [WORD_LEN-1:0] green;
   logic                active_q, active_d;
   logic [2:0]          idx_q, idx_d;
   logic [WORD_LEN-1:0] used_q, used_d;
   res_word_t           res_q, res_d;
   res_t                cur;
   logic                found;

   always_comb begin
      for (int k = 0; k < WORD_LEN; k++) begin
         green[k] = (guess[k] == target[k]);
      end
   end

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      used_d   = used_q;
      res_d    = res_q;
      cur      = RES_GRAY;
      found    = 1'b0;
      if (clr || start) begin
         active_d = start;
         idx_d    = 3'd0;
         used_d   = '0;
         res_d    = '0;
      end else if (active_q) begin
         if (green[idx_q]) begin
            cur = RES_GREEN;
         end else begin
            // lowest unclaimed non-green target slot wins the yellow
            for (int j = 0; j < WORD_LEN; j++) begin
               if (!found && target[j] == guess[idx_q]
                   && !green[j] && !used_q[j]) begin
                  found     = 1'b1;
                  used_d[j] = 1'b1;
                  cur       = RES_YELLOW;
               end
            end
         end
         res_d[idx_q] = cur;
         idx_d        = idx_q + 3'd1;
         if (idx_q == LAST_IDX) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         idx_q    <= 3'd0;
         used_q   <= '0;
         res_q    <= '0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         used_q   <= used_d;
         res_q    <= res_d;
      end
   end

   assign done      = active_q && (idx_q == LAST_IDX);
   assign all_green = &green;
   assign result    = res_q;

endmodule

// File: rtl/wordle_guess_entry.sv
// Guess assembly, submit and game FSM for the on-screen keyboard.
// Define AUTO_SUBMIT_EN to submit on the 5th letter instead of enter.
module wordle_guess_entry
   import wordle_pkg::*;
#(
   parameter int MAX_GUESSES = 6
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        Start,
   input  logic        Ack,
   input  logic        letter_valid,
   input  logic [4:0]  letter_code,
   input  logic [24:0] target_word,
   output logic [24:0] guess,
   output logic [2:0]  guess_len,
   output logic [9:0]  result,
   output logic        result_valid,
   output logic        win,
   output logic [2:0]  guess_count,
   output logic        q_I,
   output logic        q_Entry,
   output logic        q_Check,
   output logic        q_Result,
   output logic        q_Done
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_GUESSES);

   logic [4:0] state_q, state_d;
   word_t      target_q, target_d;
   word_t      guess_q, guess_d;
   logic [2:0] len_q, len_d;
   logic [2:0] count_q, count_d;
   logic       win_q, win_d;
   logic       sc_clr, sc_start, sc_done, sc_all_green;
   logic       is_letter, submit;
   res_word_t  sc_result;

   assign is_letter = letter_valid && (letter_code < LETTER_DEL);

`ifdef AUTO_SUBMIT_EN
   assign submit = is_letter && (len_q == LEN_FULL - 3'd1);
`else
   assign submit = letter_valid && (letter_code == LETTER_ENTER)
                   && (len_q == LEN_FULL);
`endif

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      guess_d  = guess_q;
      len_d    = len_q;
      count_d  = count_q;
      win_d    = win_q;
      sc_clr   = 1'b0;
      sc_start = 1'b0;
      unique case (state_q)
         ST_I: if (Start) begin
            target_d = target_word;
            guess_d  = '0;
            len_d    = 3'd0;
            count_d  = 3'd0;
            win_d    = 1'b0;
            sc_clr   = 1'b1;
            state_d  = ST_ENTRY;
         end
         ST_ENTRY: begin
            if (is_letter && len_q < LEN_FULL) begin
               guess_d[len_q] = letter_code;
               len_d          = len_q + 3'd1;
            end else if (letter_valid && letter_code == LETTER_DEL
                         && len_q != 3'd0) begin
               guess_d[len_q - 3'd1] = '0;
               len_d                 = len_q - 3'd1;
            end
            if (submit) begin
               count_d  = count_q + 3'd1;
               sc_start = 1'b1;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: if (sc_done) begin
            win_d   = sc_all_green;
            state_d = ST_RESULT;
         end
         ST_RESULT: if (Ack) begin
            if (win_q || count_q == MAX_CNT) begin
               state_d = ST_DONE;
            end else begin
               guess_d = '0;
               len_d   = 3'd0;
               state_d = ST_ENTRY;
            end
         end
         ST_DONE: if (Ack) state_d = ST_I;
         default: state_d = ST_I;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q  <= ST_I;
         target_q <= '0;
         guess_q  <= '0;
         len_q    <= 3'd0;
         count_q  <= 3'd0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         guess_q  <= guess_d;
         len_q    <= len_d;
         count_q  <= count_d;
         win_q    <= win_d;
      end
   end

   wordle_guess_scorer u_scorer (
      .clk       (Clk),
      .reset     (reset),
      .clr       (sc_clr),
      .start     (sc_start),
      .guess     (guess_q),
      .target    (target_q),
      .done      (sc_done),
      .all_green (sc_all_green),
      .result    (sc_result)
   );

   assign guess        = guess_q;
   assign guess_len    = len_q;
   assign result       = sc_result;
   assign win          = win_q;
   assign guess_count  = count_q;
   assign q_I          = state_q[0];
   assign q_Entry      = state_q[1];
   assign q_Check      = state_q[2];
   assign q_Result     = state_q[3];
   assign q_Done       = state_q[4];
   assign result_valid = q_Result | q_Done;

endmodule

// File: tb/tb_wordle_guess_entry.sv
// Scoreboard bench for wordle_guess_entry (default build).
// Stimulus queues expectations; a negedge monitor compares them.
module tb_wordle_guess_entry;

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic        Ack = 1'b0;
   logic        letter_valid = 1'b0;
   logic [4:0]  letter_code = 5'd0;
   logic [24:0] target_word = '0;
   logic [24:0] guess;
   logic [2:0]  guess_len;
   logic [9:0]  result;
   logic        result_valid;
   logic        win;
   logic [2:0]  guess_count;
   logic        q_I, q_Entry, q_Check, q_Result, q_Done;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] SI = 5'b00001;
   localparam logic [4:0] SE = 5'b00010;
   localparam logic [4:0] SC = 5'b00100;
   localparam logic [4:0] SR = 5'b01000;
   localparam logic [4:0] SD = 5'b10000;

   typedef struct {
      string       name;
      logic [4:0]  st;
      logic [2:0]  len;
      logic [24:0] g;
      logic [2:0]  cnt;
      logic        wn;
      logic [9:0]  res;
   } snap_t;

   typedef struct {
      string      name;
      logic [9:0] res;
      logic       wn;
      logic [2:0] cnt;
   } rexp_t;

   snap_t snap_q[$];
   rexp_t res_q[$];

   wordle_guess_entry #(.MAX_GUESSES(6)) dut (
      .Clk          (Clk),
      .reset        (reset),
      .Start        (Start),
      .Ack          (Ack),
      .letter_valid (letter_valid),
      .letter_code  (letter_code),
      .target_word  (target_word),
      .guess        (guess),
      .guess_len    (guess_len),
      .result       (result),
      .result_valid (result_valid),
      .win          (win),
      .guess_count  (guess_count),
      .q_I          (q_I),
      .q_Entry      (q_Entry),
      .q_Check      (q_Check),
      .q_Result     (q_Result),
      .q_Done       (q_Done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [24:0] w(input string s);
      logic [24:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[i*5 +: 5] = 5'(s[i] - 8'd65);
      return r;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic key(input logic [4:0] c);
      letter_valid = 1'b1;
      letter_code  = c;
      tick();
      letter_valid = 1'b0;
   endtask

   task automatic type_word(input string s);
      for (int i = 0; i < s.len(); i++) key(5'(s[i] - 8'd65));
   endtask

   task automatic ack();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
   endtask

   task automatic start_game(input string s);
      target_word = w(s);
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic snap(input string n, input logic [4:0] st,
                       input logic [2:0] len, input logic [24:0] g,
                       input logic [2:0] cnt, input logic wn,
                       input logic [9:0] res);
      snap_t e;
      e.name = n; e.st = st; e.len = len; e.g = g;
      e.cnt = cnt; e.wn = wn; e.res = res;
      snap_q.push_back(e);
   endtask

   task automatic exp_res(input string n, input logic [9:0] res,
                          input logic wn, input logic [2:0] cnt);
      rexp_t e;
      e.name = n; e.res = res; e.wn = wn; e.cnt = cnt;
      res_q.push_back(e);
   endtask

   task automatic wait_result(input string n);
      for (int i = 0; i < 20 && !result_valid; i++) tick();
      if (!result_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: result_valid timeout, got 0 want 1", n);
      end
   endtask

   // monitor: drains snapshot expectations and scores each result
   initial begin
      snap_t e;
      rexp_t r;
      int    chk;
      logic  rv_prev;
      chk = 0;
      rv_prev = 1'b0;
      forever begin
         @(negedge Clk);
         while (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            checks++;
            if ({q_Done, q_Result, q_Check, q_Entry, q_I, guess_len,
                 guess, guess_count, win, result} !==
                {e.st, e.len, e.g, e.cnt, e.wn, e.res}) begin
               errors++;
               $display("FAIL %s: got st=%b len=%0d g=%h cnt=%0d win=%b res=%h want st=%b len=%0d g=%h cnt=%0d win=%b res=%h",
                        e.name, {q_Done, q_Result, q_Check, q_Entry, q_I},
                        guess_len, guess, guess_count, win, result,
                        e.st, e.len, e.g, e.cnt, e.wn, e.res);
            end
         end
         if (q_Check) begin
            chk++;
         end else if (result_valid && !rv_prev) begin
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got res=%h want none",
                        result);
            end else begin
               r = res_q.pop_front();
               if ({result, win, guess_count} !== {r.res, r.wn, r.cnt}) begin
                  errors++;
                  $display("FAIL %s: got res=%h win=%b cnt=%0d want res=%h win=%b cnt=%0d",
                           r.name, result, win, guess_count,
                           r.res, r.wn, r.cnt);
               end
            end
            checks++;
            if (chk != 5) begin
               errors++;
               $display("FAIL check_cycles: got %0d want 5", chk);
            end
            chk = 0;
         end else begin
            chk = 0;
         end
         rv_prev = result_valid;
      end
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      snap("reset", SI, 0, '0, 0, 0, '0);

      // game 1: immediate win
      start_game("CRANE");
      snap("start", SE, 0, '0, 0, 0, '0);
      type_word("CRANE");
      snap("typed_crane", SE, 5, w("CRANE"), 0, 0, '0);
      exp_res("res_crane", 10'h2AA, 1'b1, 3'd1);
      key(5'd27);
      wait_result("crane");
      ack();
      snap("done_win", SD, 5, w("CRANE"), 1, 1, 10'h2AA);
      ack();
      snap("idle_hold", SI, 5, w("CRANE"), 1, 1, 10'h2AA);

      // game 2: duplicate-letter scoring and running out of guesses
      start_game("APPLE");
      type_word("PAPAL");
      exp_res("res_papal", 10'h125, 1'b0, 3'd1);
      key(5'd27);
      wait_result("papal");
      ack();
      snap("back_entry", SE, 0, '0, 1, 0, 10'h125);

      key(5'd0);
      snap("del_a", SE, 1, w("A"), 1, 0, 10'h125);
      key(5'd1);
      snap("del_ab", SE, 2, w("AB"), 1, 0, 10'h125);
      key(5'd26);
      snap("del_1", SE, 1, w("A"), 1, 0, 10'h125);
      key(5'd26);
      snap("del_0", SE, 0, '0, 1, 0, 10'h125);
      key(5'd26);
      snap("del_empty", SE, 0, '0, 1, 0, 10'h125);
      type_word("ABC");
      key(5'd27);
      snap("enter_short", SE, 3, w("ABC"), 1, 0, 10'h125);
      repeat (3) key(5'd26);

      type_word("CRANE");
      key(5'd25);
      snap("sixth_letter", SE, 5, w("CRANE"), 1, 0, 10'h125);
      exp_res("res_crane_apple", 10'h210, 1'b0, 3'd2);
      key(5'd27);
      snap("in_check", SC, 5, w("CRANE"), 2, 0, '0);
      key(5'd0);
      wait_result("crane_apple");
      key(5'd25);
      snap("key_in_result", SR, 5, w("CRANE"), 2, 0, 10'h210);
      Ack = 1'b1;
      letter_valid = 1'b1;
      letter_code = 5'd0;
      tick();
      Ack = 1'b0;
      letter_valid = 1'b0;
      snap("ack_with_key", SE, 0, '0, 2, 0, 10'h210);

      for (int n = 3; n <= 6; n++) begin
         type_word("ZZZZZ");
         exp_res($sformatf("res_zzzzz_%0d", n), '0, 1'b0, 3'(n));
         key(5'd27);
         wait_result("zzzzz");
         ack();
      end
      snap("done_lost", SD, 5, w("ZZZZZ"), 6, 0, '0);
      ack();
      snap("idle_lost", SI, 5, w("ZZZZZ"), 6, 0, '0);

      // game 3: reset during the third scoring cycle
      start_game("CRANE");
      type_word("CRANE");
      key(5'd27);
      snap("check_1", SC, 5, w("CRANE"), 1, 0, '0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      snap("mid_check_reset", SI, 0, '0, 0, 0, '0);
      repeat (3) tick();

      checks += snap_q.size() + res_q.size();
      errors += snap_q.size() + res_q.size();
      if (res_q.size() != 0)
         $display("FAIL missing_results: got %0d left want 0",
                  res_q.size());
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
